// File: rtl/spi_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// spi_ram_arbiter_if
// Bundles the two requester channels, the RAM command/read-data channel and
// the timeout flag of the command-RAM arbiter.
//   slave  : arbiter side (accepts requests, drives RAM commands/responses)
//   master : requester/RAM side (drives requests and RAM read data)
// ----------------------------------------------------------------------------
interface spi_ram_arbiter_if;
    logic [9:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] rsp0_data;
    logic       rsp0_valid;
    logic [9:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] rsp1_data;
    logic       rsp1_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       timeout_err;

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid, ram_dout, ram_tx_valid,
        output req0_ready, rsp0_data, rsp0_valid, req1_ready, rsp1_data, rsp1_valid,
        output ram_din, ram_rx_valid, timeout_err
    );

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid, ram_dout, ram_tx_valid,
        input  req0_ready, rsp0_data, rsp0_valid, req1_ready, rsp1_data, rsp1_valid,
        input  ram_din, ram_rx_valid, timeout_err
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// spi_ram_arbiter
// Shares the single-port command RAM between two requesters. A grant covers a
// whole transaction (address word, data word and any read-data return).
// Ties in IDLE go to the requester that was not granted last.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : requester 0/1 command + response channels, RAM command
//            (ram_din/ram_rx_valid), RAM read data (ram_dout/ram_tx_valid),
//            timeout_err pulse
// ----------------------------------------------------------------------------
module spi_ram_arbiter #(
    parameter int RD_TIMEOUT   = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_ram_arbiter_if.slave bus
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > RD_TIMEOUT) ? LOCK_TIMEOUT : RD_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // Counter value on the last waiting cycle; timeout fires while it is held.
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [9:0]      ram_din_q, ram_din_d;
    logic            ram_rx_valid_q, ram_rx_valid_d;
    logic [7:0]      rsp0_data_q, rsp0_data_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic [7:0]      rsp1_data_q, rsp1_data_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic            timeout_err_q, timeout_err_d;

    logic            ready0_s, ready1_s;
    logic            acc_s;
    logic [9:0]      acc_word_s;
    logic            rsp_fire_s;
    logic [7:0]      rsp_data_s;

    // Grant decision and combinational ready; ready is only raised together with valid.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // last_grant_q = 1 means requester 1 went last, so 0 wins a tie
                if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
                    ready0_s = 1'b1;
                end else if (bus.req1_valid) begin
                    ready1_s = 1'b1;
                end else begin
                    ready0_s = 1'b0;
                    ready1_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (owner_q) begin
                    ready1_s = bus.req1_valid;
                end else begin
                    ready0_s = bus.req0_valid;
                end
            end
            default: begin
                ready0_s = 1'b0;
                ready1_s = 1'b0;
            end
        endcase
        // Nothing is accepted while reset is applied.
        ready0_s   = ready0_s & rst_n;
        ready1_s   = ready1_s & rst_n;
        acc_s      = ready0_s | ready1_s;
        acc_word_s = ready1_s ? bus.req1_data : bus.req0_data;
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        ram_din_d      = ram_din_q;
        ram_rx_valid_d = 1'b0;
        rsp0_data_d    = rsp0_data_q;
        rsp0_valid_d   = 1'b0;
        rsp1_data_d    = rsp1_data_q;
        rsp1_valid_d   = 1'b0;
        timeout_err_d  = 1'b0;
        rsp_fire_s     = 1'b0;
        rsp_data_s     = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    last_grant_d = ready1_s;
                    owner_d      = ready1_s;
                end else begin
                    last_grant_d = last_grant_q;
                end
            end
            ST_LOCKED: begin
                if (acc_s) begin
                    cnt_d = {CW{1'b0}};
                end else if (cnt_q == LOCK_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_RD: begin
                // Data arriving on the timeout cycle takes precedence.
                if (bus.ram_tx_valid) begin
                    rsp_fire_s = 1'b1;
                    rsp_data_s = bus.ram_dout;
                    state_d    = ST_IDLE;
                    cnt_d      = {CW{1'b0}};
                end else if (cnt_q == RD_LAST) begin
                    rsp_fire_s    = 1'b1;
                    rsp_data_s    = 8'h00;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        if (acc_s) begin
            ram_din_d      = acc_word_s;
            ram_rx_valid_d = 1'b1;
            cnt_d          = {CW{1'b0}};
            case (acc_word_s[9:8])
                2'b01:   state_d = ST_IDLE;     // data word closes a write
                2'b11:   state_d = ST_WAIT_RD;  // read data requested
                default: state_d = ST_LOCKED;   // address word opens a transaction
            endcase
        end else begin
            ram_din_d = ram_din_q;
        end

        if (rsp_fire_s) begin
            if (owner_q) begin
                rsp1_data_d  = rsp_data_s;
                rsp1_valid_d = 1'b1;
            end else begin
                rsp0_data_d  = rsp_data_s;
                rsp0_valid_d = 1'b1;
            end
        end else begin
            rsp0_valid_d = 1'b0;
            rsp1_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            cnt_q          <= {CW{1'b0}};
            ram_din_q      <= 10'h000;
            ram_rx_valid_q <= 1'b0;
            rsp0_data_q    <= 8'h00;
            rsp0_valid_q   <= 1'b0;
            rsp1_data_q    <= 8'h00;
            rsp1_valid_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            rsp0_data_q    <= rsp0_data_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_data_q    <= rsp1_data_d;
            rsp1_valid_q   <= rsp1_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign bus.req0_ready   = ready0_s;
    assign bus.req1_ready   = ready1_s;
    assign bus.ram_din      = ram_din_q;
    assign bus.ram_rx_valid = ram_rx_valid_q;
    assign bus.rsp0_data    = rsp0_data_q;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp1_data    = rsp1_data_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_ram_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (mode + owner + absolute deadline cycles) predicts every
// accepted word, response and timeout; predictions go into per-output queues
// that an independent monitor drains whenever the DUT presents an output.
// ----------------------------------------------------------------------------
module tb_spi_ram_arbiter;

    localparam int RD_TO   = 4;
    localparam int LOCK_TO = 16;
    localparam int MF = 0;  // free
    localparam int ML = 1;  // locked by owner
    localparam int MR = 2;  // waiting for read data

    logic clk = 1'b0;
    logic rst_n;
    spi_ram_arbiter_if bus();

    spi_ram_arbiter #(.RD_TIMEOUT(RD_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [9:0] data;
    } ev_t;

    // 0: ram_din, 1: rsp0, 2: rsp1, 3: timeout_err
    ev_t   evq [4][$];
    string knm [4] = '{"ram_din", "rsp0", "rsp1", "timeout_err"};

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_mode = MF;
    int   m_owner = 0;
    int   m_last = 1;
    int   m_lock_dl = 0;
    int   m_rd_dl = 0;
    logic exp_r0, exp_r1, acc0, acc1, dut_r0, dut_r1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic [9:0] d);
        ev_t e;
        e.cyc  = c;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one call per cycle, decides acceptance and predicts outputs for cycle+1.
    task automatic model(input logic rn, input logic v0, input logic [9:0] d0,
                         input logic v1, input logic [9:0] d1,
                         input logic tx, input logic [7:0] dout);
        int win;
        logic [9:0] w;
        win = -1;
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (!rn) begin
            m_mode  = MF;
            m_last  = 1;
            m_owner = 0;
        end else begin
            if (m_mode == MF) begin
                if (v0 && v1)  win = (m_last == 0) ? 1 : 0;
                else if (v0)   win = 0;
                else if (v1)   win = 1;
                if (win >= 0) m_last = win;
            end else if (m_mode == ML) begin
                if ((m_owner == 0 && v0) || (m_owner == 1 && v1)) begin
                    win = m_owner;
                end else if (cyc == m_lock_dl) begin
                    evq[3].push_back(mk(cyc + 1, 10'h000));
                    m_mode = MF;
                end
            end else begin
                if (tx) begin
                    evq[1 + m_owner].push_back(mk(cyc + 1, {2'b00, dout}));
                    m_mode = MF;
                end else if (cyc == m_rd_dl) begin
                    evq[1 + m_owner].push_back(mk(cyc + 1, 10'h000));
                    evq[3].push_back(mk(cyc + 1, 10'h000));
                    m_mode = MF;
                end
            end
            if (win >= 0) begin
                w = (win == 1) ? d1 : d0;
                if (win == 1) exp_r1 = 1'b1;
                else          exp_r0 = 1'b1;
                evq[0].push_back(mk(cyc + 1, w));
                m_owner = win;
                case (w[9:8])
                    2'b01:   m_mode = MF;
                    2'b11:   begin m_mode = MR; m_rd_dl   = cyc + RD_TO;   end
                    default: begin m_mode = ML; m_lock_dl = cyc + LOCK_TO; end
                endcase
            end
        end
        acc0 = exp_r0;
        acc1 = exp_r1;
    endtask

    // Drive one cycle of inputs, check ready mid-cycle, end just after the next edge.
    task automatic step(input logic rn, input logic v0, input logic [9:0] d0,
                        input logic v1, input logic [9:0] d1,
                        input logic tx, input logic [7:0] dout);
        rst_n            = rn;
        bus.req0_valid   = v0;
        bus.req0_data    = d0;
        bus.req1_valid   = v1;
        bus.req1_data    = d1;
        bus.ram_tx_valid = tx;
        bus.ram_dout     = dout;
        @(negedge clk);
        dut_r0 = bus.req0_ready;
        dut_r1 = bus.req1_ready;
        model(rn, v0, d0, v1, d1, tx, dout);
        chk("req0_ready", 32'(dut_r0), 32'(exp_r0));
        chk("req1_ready", 32'(dut_r1), 32'(exp_r1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ram_din"},      32'(bus.ram_din),      32'd0);
        chk({nm, "_ram_rx_valid"}, 32'(bus.ram_rx_valid), 32'd0);
        chk({nm, "_rsp0_data"},    32'(bus.rsp0_data),    32'd0);
        chk({nm, "_rsp0_valid"},   32'(bus.rsp0_valid),   32'd0);
        chk({nm, "_rsp1_data"},    32'(bus.rsp1_data),    32'd0);
        chk({nm, "_rsp1_valid"},   32'(bus.rsp1_valid),   32'd0);
        chk({nm, "_timeout_err"},  32'(bus.timeout_err),  32'd0);
        chk({nm, "_req0_ready"},   32'(bus.req0_ready),   32'd0);
        chk({nm, "_req1_ready"},   32'(bus.req1_ready),   32'd0);
    endtask

    // Monitor: every cycle each output either matches the queued prediction or stays idle.
    always @(negedge clk) begin
        logic       fire [4];
        logic [9:0] val  [4];
        ev_t        e;
        fire[0] = bus.ram_rx_valid; val[0] = bus.ram_din;
        fire[1] = bus.rsp0_valid;   val[1] = {2'b00, bus.rsp0_data};
        fire[2] = bus.rsp1_valid;   val[2] = {2'b00, bus.rsp1_data};
        fire[3] = bus.timeout_err;  val[3] = 10'h000;
        for (int k = 0; k < 4; k++) begin
            if (evq[k].size() > 0 && evq[k][0].cyc <= cyc) begin
                e = evq[k].pop_front();
                chk({knm[k], "_valid"}, 32'(fire[k]), 32'd1);
                if (fire[k] === 1'b1) chk({knm[k], "_data"}, 32'(val[k]), 32'(e.data));
            end else begin
                chk({knm[k], "_valid"}, 32'(fire[k]), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rv0, rv1, quiet;
        logic [9:0] rd0, rd1;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_data = 10'h000;
        bus.req1_valid = 1'b0; bus.req1_data = 10'h000;
        bus.ram_tx_valid = 1'b0; bus.ram_dout = 8'h00;
        @(posedge clk);
        #1;

        // Reset: outputs and readies held at 0 even with both requesters valid.
        step(1'b0, 1'b1, 10'h3FF, 1'b1, 10'h3FF, 1'b0, 8'h00);
        check_zero("reset");

        // Single write from requester 0.
        step(1'b1, 1'b1, 10'h005, 1'b0, 10'h000, 1'b0, 8'h00);
        chk("wr_addr_fwd", 32'(bus.ram_din), 32'h005);
        step(1'b1, 1'b1, 10'h1A5, 1'b0, 10'h000, 1'b0, 8'h00);
        chk("wr_data_fwd", 32'(bus.ram_din), 32'h1A5);
        chk("wr_data_vld", 32'(bus.ram_rx_valid), 32'd1);
        idle(2);

        // Read by requester 1, RAM answers two cycles after the rd-data word.
        step(1'b1, 1'b0, 10'h000, 1'b1, 10'h20C, 1'b0, 8'h00);
        step(1'b1, 1'b0, 10'h000, 1'b1, 10'h300, 1'b0, 8'h00);
        idle(1);
        step(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h3C);
        chk("rd1_rsp_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("rd1_rsp_data",  32'(bus.rsp1_data),  32'h3C);
        chk("rd1_rsp0_quiet", 32'(bus.rsp0_valid), 32'd0);

        // Contention out of reset: requester 0 first, requester 1 on the next tie.
        step(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
        step(1'b1, 1'b1, 10'h2AA, 1'b1, 10'h211, 1'b0, 8'h00);
        chk("tie0_r0", 32'(dut_r0), 32'd1);
        step(1'b1, 1'b1, 10'h3AA, 1'b1, 10'h211, 1'b0, 8'h00);
        chk("locked_r1", 32'(dut_r1), 32'd0);
        step(1'b1, 1'b0, 10'h000, 1'b1, 10'h211, 1'b1, 8'h77);
        chk("waitrd_r1", 32'(dut_r1), 32'd0);
        step(1'b1, 1'b1, 10'h201, 1'b1, 10'h211, 1'b0, 8'h00);
        chk("tie1_r1", 32'(dut_r1), 32'd1);
        chk("tie1_r0", 32'(dut_r0), 32'd0);
        step(1'b1, 1'b1, 10'h201, 1'b1, 10'h322, 1'b0, 8'h00);
        step(1'b1, 1'b1, 10'h201, 1'b0, 10'h000, 1'b1, 8'h44);
        chk("tie1_rsp1", 32'(bus.rsp1_data), 32'h44);
        step(1'b1, 1'b1, 10'h201, 1'b0, 10'h000, 1'b0, 8'h00);
        step(1'b1, 1'b1, 10'h101, 1'b0, 10'h000, 1'b0, 8'h00);

        // Lock timeout: owner silent for LOCK_TO cycles, requester 1 waiting.
        step(1'b1, 1'b1, 10'h010, 1'b0, 10'h000, 1'b0, 8'h00);
        for (int i = 0; i < LOCK_TO; i++) begin
            step(1'b1, 1'b0, 10'h000, 1'b1, 10'h155, 1'b0, 8'h00);
            chk("lock_r1_blocked", 32'(dut_r1), 32'd0);
        end
        chk("lock_timeout_err", 32'(bus.timeout_err), 32'd1);
        chk("lock_no_ram",      32'(bus.ram_rx_valid), 32'd0);
        step(1'b1, 1'b0, 10'h000, 1'b1, 10'h155, 1'b0, 8'h00);
        chk("after_lock_r1", 32'(dut_r1), 32'd1);

        // Read timeout at N+RD_TO+1, then data on the timeout cycle wins.
        step(1'b1, 1'b1, 10'h300, 1'b0, 10'h000, 1'b0, 8'h00);
        idle(RD_TO);
        chk("rdto_valid", 32'(bus.rsp0_valid),  32'd1);
        chk("rdto_data",  32'(bus.rsp0_data),   32'h00);
        chk("rdto_err",   32'(bus.timeout_err), 32'd1);
        step(1'b1, 1'b1, 10'h3FF, 1'b0, 10'h000, 1'b0, 8'h00);
        idle(RD_TO - 1);
        step(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'hA5);
        chk("rdlate_valid", 32'(bus.rsp0_valid),  32'd1);
        chk("rdlate_data",  32'(bus.rsp0_data),   32'hA5);
        chk("rdlate_noerr", 32'(bus.timeout_err), 32'd0);

        // Reset during WAIT_RD, then a stale ram_tx_valid and a tie.
        step(1'b1, 1'b0, 10'h000, 1'b1, 10'h300, 1'b0, 8'h00);
        idle(1);
        step(1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
        check_zero("midrst");
        step(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h99);
        chk("stale_rsp1", 32'(bus.rsp1_valid), 32'd0);
        step(1'b1, 1'b1, 10'h101, 1'b1, 10'h1FF, 1'b0, 8'h00);
        chk("rst_tie_r0", 32'(dut_r0), 32'd1);
        chk("rst_tie_r1", 32'(dut_r1), 32'd0);
        step(1'b1, 1'b0, 10'h000, 1'b1, 10'h1FF, 1'b0, 8'h00);

        // Randomized traffic; requesters hold a word until the model accepts it.
        rv0 = 1'b0; rv1 = 1'b0; rd0 = 10'h000; rd1 = 10'h000; quiet = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) quiet = ($urandom_range(0, 2) == 0);
            if (!(rv0 && !acc0)) begin
                rv0 = quiet ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
                rd0 = 10'($urandom_range(0, 1023));
            end
            if (!(rv1 && !acc1)) begin
                rv1 = quiet ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
                rd1 = 10'($urandom_range(0, 1023));
            end
            step(($urandom_range(0, 299) != 0), rv0, rd0, rv1, rd1,
                 ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
        end

        idle(LOCK_TO + RD_TO + 4);
        for (int k = 0; k < 4; k++) chk({knm[k], "_drained"}, 32'(evq[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Two-requester arbiter that shares the single-port command RAM (10-bit command word in, 8-bit read data out) between the SPI slave path and a second on-chip requester. It grants the RAM atomically per transaction: an address word plus its following data word, including the read-data return. Round-robin fairness is enforced between the two requesters. Timeouts stop a stalled owner or a silent RAM from locking the resource.

## Interface
Parameters:
- RD_TIMEOUT, 4: cycles to wait for `ram_tx_valid` after issuing a read-data command.
- LOCK_TIMEOUT, 16: idle cycles the owner may leave a locked transaction open before it is released.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_data  in  10  requester 0 command word; [9:8] = cmd (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] = payload.
- req0_valid  in  1  requester 0 word present.
- req0_ready  out  1  requester 0 word accepted this cycle (combinational from state and valids).
- rsp0_data  out  8  read data returned to requester 0.
- rsp0_valid  out  1  one-cycle pulse qualifying rsp0_data.
- req1_data, req1_valid, req1_ready, rsp1_data, rsp1_valid: same as requester 0, for requester 1.
- ram_din  out  10  command word to RAM (registered).
- ram_rx_valid  out  1  one-cycle pulse qualifying ram_din.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.
- timeout_err  out  1  one-cycle pulse on any timeout.

## Operation
- States: IDLE, LOCKED (owner holds grant, awaiting data word), WAIT_RD (awaiting RAM read data).
- IDLE: if exactly one reqX_valid, grant X. If both, grant the requester not recorded in `last_grant`. The granted reqX_ready = 1 and the word is accepted. `last_grant` <= X.
  - Accepted cmd[0] = 0 (address word): go to LOCKED with owner = X.
  - Accepted cmd = 01: single-word write; stay in IDLE.
  - Accepted cmd = 11: go to WAIT_RD with owner = X.
- LOCKED: only owner's ready may be high; the non-owner's ready = 0.
  - Owner word with cmd[0] = 0: accepted and forwarded; stay LOCKED; idle counter cleared.
  - Owner word cmd = 01: accepted; return to IDLE.
  - Owner word cmd = 11: accepted; go to WAIT_RD.
  - No owner word: idle counter increments. At LOCK_TIMEOUT, pulse timeout_err and return to IDLE; nothing is sent to RAM.
- WAIT_RD: both readys = 0. The read counter increments each cycle without ram_tx_valid.
  - ram_tx_valid: rspOWNER_data <= ram_dout, rspOWNER_valid pulses; return to IDLE.
  - Counter reaches RD_TIMEOUT: rspOWNER_data <= 8'h00, rspOWNER_valid and timeout_err pulse; return to IDLE.
  - ram_tx_valid in the same cycle the timeout is reached: data wins; no timeout_err.
- ram_tx_valid outside WAIT_RD is ignored; no rsp is produced.
- Every accepted word is forwarded unmodified: ram_din <= word, ram_rx_valid pulses.
- The non-owner rsp is never asserted.

## Timing
- Reset (rst_n = 0 at a clock edge): state IDLE, last_grant = 1 (requester 0 wins first tie), counters 0. All outputs 0: ram_din, ram_rx_valid, rsp*_data, rsp*_valid, timeout_err, req*_ready.
- Reset mid-transaction: the transaction is abandoned and no rsp is issued. A ram_tx_valid arriving after reset is ignored.
- Acceptance at cycle N gives ram_rx_valid = 1 at N+1 with ram_din = accepted word.
- Read: rd-data accepted at N, ram_tx_valid at cycle M (M >= N+1). rsp valid at M+1.
- Timeout: the counter starts at N+1. With no data, rsp/timeout_err are asserted at N+RD_TIMEOUT+1.
- Back-to-back: a new grant is possible in the cycle after returning to IDLE. The maximum throughput is one word per cycle for the owner.
- Ready is combinational. Requesters must hold data/valid until ready is seen.

## Test plan
- Single write, req0 only: words 0x005 then 0x1A5 -> ram_din 0x005 then 0x1A5, each with ram_rx_valid one cycle after acceptance. No rsp. State IDLE after.
- Read, req1: words 0x20C then 0x300. RAM returns ram_tx_valid with 0x3C two cycles later -> rsp1_valid one cycle after, rsp1_data = 0x3C. rsp0_valid stays 0.
- Contention out of reset: both valid with rd-addr words -> req0 granted first. req1_ready stays 0 until req0 finishes its 0x3xx read. req1 granted on the next tie.
- Lock timeout: req0 sends 0x010 then goes silent for 16 cycles -> timeout_err pulse, return to IDLE. Then req1 is immediately grantable.
- Read timeout: rd-data accepted, RAM silent -> rsp valid with 0x00 plus timeout_err at N+5. Repeat with ram_tx_valid exactly on the timeout cycle -> data returned, no error.
- Reset during WAIT_RD, followed by a late ram_tx_valid -> no rsp, all outputs 0, next tie goes to req0.
